ysyx_22040365_addi_core: RTL and testbench
==========================================

// Module: ysyx_22040365_addi_core
// PURPOSE
//  - Single-cycle RV64I datapath slice implementing ADDI and EBREAK only.
//  - Integrates three parts: instruction decoder (id), 32x64 register file (regfile)
//    and execute adder (ex).
//  - Sits under the NPC top; the top feeds one 32-bit instruction per cycle and
//    observes the writeback value on out.
//  - The top forwards out / halt to the simulator DPI hook.
// PARAMETERS
//  - XLEN    64  datapath / register width
//  - NREGS   32  architectural registers; x0 hardwired to zero
// PORTS
//  - clk    in   1      system clock; all state changes on the rising edge
//  - rst    in   1      reset, asynchronous, active-high; clears the register file
//  - inst   in   32     instruction for the current cycle (held stable by the driver)
//  - out    out  64     ex result (rd writeback data), combinational
//  - wen    out  1      1 when the current inst writes rd this cycle
//  - halt   out  1      1 when inst == EBREAK (0x00100073), combinational
// BEHAVIOUR
//  - Decode (combinational)
//    - opcode = inst[6:0], rd = inst[11:7], funct3 = inst[14:12], rs1 = inst[19:15].
//    - imm_I = sign-extend inst[31:20] to 64 bits.
//    - inst_type (2b):
//      - 2'b01 ADDI: opcode 7'b0010011 and funct3 3'b000.
//      - 2'b10 EBREAK: inst == 32'h00100073.
//      - 2'b00 any other encoding (illegal/unsupported).
//    - ren_rs1 = 1 only for ADDI.
//  - Regfile
//    - Read port: asynchronous; rdata = regs[raddr] when ren_rs1 = 1 and raddr != 0,
//      else 0.
//    - Write port: on posedge clk, regs[waddr] <= wdata when wen = 1 and waddr != 0.
//    - Writes to x0 are discarded; x0 always reads 0.
//    - Read-during-write returns the old value; the new value is visible the cycle
//      after the edge. No bypass.
//  - Execute (combinational)
//    - ADDI: out = rs1_data + imm_I, modulo 2^64; overflow wraps silently
//      (7FFF..FF + 1 = 8000..00). wen = 1.
//    - EBREAK: out = 0, wen = 0, halt = 1.
//    - Other: out = 0, wen = 0, halt = 0. No trap, no state change.
//  - Latency
//    - out / wen / halt are valid in the same cycle as inst (zero latency).
//    - Register update occurs at the next rising edge.
//  - Reset
//    - rst = 1 clears regs[1..31] to 0 immediately, independent of clk.
//    - While rst = 1, no write occurs, even with wen = 1 at an edge.
//    - Outputs stay combinational during reset; e.g. ADDI out = 0 + imm.
//    - Deassertion resumes normal writes at the first subsequent rising edge.
//  - Simultaneous events
//    - Reset asserted coincident with a write edge: reset wins, register stays 0.
// STRUCTURE
//  - Shared defines/package: XLEN, opcode OP_IMM 7'b0010011, FUNCT3_ADDI, EBREAK
//    encoding, and the inst_type encodings (INST_NONE/INST_ADDI/INST_EBREAK).
//  - One natural sub-module: ysyx_22040365_rf (32x64 register file,
//    async clear, 1R1W).
//  - Decode and the adder are inlined in this module.
// TESTING
//  1. Reset; inst=0x00500093 (addi x1,x0,5)
//     -> out=5, wen=1 in that cycle; after the edge, x1=5.
//  2. Then inst=0xfff08113 (addi x2,x1,-1)
//     -> out=4; after the edge, addi x5,x2,0 (0x00010293) gives out=4.
//  3. inst=0x00700013 (addi x0,x0,7)
//     -> out=7, wen=1, but x0 stays 0; next, 0x00000193 (addi x3,x0,0) gives out=0.
//  4. inst=0x80000213 (addi x4,x0,-2048)
//     -> out=64'hFFFF_FFFF_FFFF_F800; x1=64'h7FFF_FFFF_FFFF_FFFF then addi x1,x1,1
//        -> out=64'h8000_0000_0000_0000.
//  5. inst=0x00100073 -> halt=1, wen=0, out=0.
//     inst=0x00000000 -> halt=0, wen=0, out=0, no register changes.
//  6. With x1=5, pulse rst between edges -> addi x6,x1,0 (0x00008313) reads out=0
//     immediately; with rst held across an edge and wen=1 -> rd remains 0.

Source files
------------

// File: rtl/ysyx_22040365_addi_core_pkg.sv
// Shared widths, opcode/funct3 constants and instruction-class encoding
// for the ADDI/EBREAK datapath slice.
package ysyx_22040365_addi_core_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RADDR = $clog2(NREGS);

  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [2:0]  FUNCT3_ADDI = 3'b000;
  localparam logic [31:0] EBREAK      = 32'h0010_0073;

  typedef enum logic [1:0] {
    INST_NONE   = 2'b00,
    INST_ADDI   = 2'b01,
    INST_EBREAK = 2'b10
  } inst_type_e;

endpackage

// File: rtl/ysyx_22040365_rf.sv
// 32x64 register file: one asynchronous read port, one synchronous write port,
// asynchronous clear. x0 reads zero and ignores writes.
module ysyx_22040365_rf
  import ysyx_22040365_addi_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ren,
  input  logic [RADDR-1:0] raddr,
  output logic [XLEN-1:0]  rdata,
  input  logic             wen,
  input  logic [RADDR-1:0] waddr,
  input  logic [XLEN-1:0]  wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the pre-edge value.
  always_comb begin
    rdata = '0;
    if (ren && (raddr != '0)) rdata = regs[raddr];
  end

endmodule

// File: rtl/ysyx_22040365_addi_core.sv
// Single-cycle RV64I slice: decodes ADDI/EBREAK, reads rs1, adds the
// sign-extended I-immediate and writes rd at the next rising edge.
module ysyx_22040365_addi_core
  import ysyx_22040365_addi_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] out,
  output logic            wen,
  output logic            halt
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [RADDR-1:0] rd;
  logic [RADDR-1:0] rs1;
  logic [XLEN-1:0]  imm_i;
  logic [XLEN-1:0]  rs1_data;
  inst_type_e       inst_type;
  logic             ren_rs1;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};

  always_comb begin
    inst_type = INST_NONE;
    if (inst == EBREAK) begin
      inst_type = INST_EBREAK;
    end else if ((opcode == OP_IMM) && (funct3 == FUNCT3_ADDI)) begin
      inst_type = INST_ADDI;
    end
  end

  assign ren_rs1 = (inst_type == INST_ADDI);

  ysyx_22040365_rf u_rf (
    .clk   (clk),
    .rst   (rst),
    .ren   (ren_rs1),
    .raddr (rs1),
    .rdata (rs1_data),
    .wen   (wen),
    .waddr (rd),
    .wdata (out)
  );

  always_comb begin
    out  = '0;
    wen  = 1'b0;
    halt = 1'b0;
    unique case (inst_type)
      INST_ADDI: begin
        out = rs1_data + imm_i;
        wen = 1'b1;
      end
      INST_EBREAK: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040365_addi_core.sv
// Directed bench for the ADDI/EBREAK slice: a vector table run in order,
// followed by hand-written asynchronous reset sequences.
module tb_ysyx_22040365_addi_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [63:0] out;
  logic        wen;
  logic        halt;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040365_addi_core dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .out  (out),
    .wen  (wen),
    .halt (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] out;
    logic        wen;
    logic        halt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] exp_out,
                       input logic exp_wen, input logic exp_halt);
    n_checks++;
    if (out !== exp_out || wen !== exp_wen || halt !== exp_halt) begin
      n_fail++;
      $display("FAIL %s: got out=%h wen=%b halt=%b, expected out=%h wen=%b halt=%b",
               name, out, wen, halt, exp_out, exp_wen, exp_halt);
    end
  endtask

  // Drive one instruction mid-cycle and check outputs before the next rising edge.
  task automatic apply(input string name, input logic [31:0] i,
                       input logic [63:0] exp_out, input logic exp_wen,
                       input logic exp_halt);
    @(negedge clk);
    inst = i;
    #1;
    check(name, exp_out, exp_wen, exp_halt);
  endtask

  initial begin
    vecs.push_back('{"addi_x1_5",      32'h0050_0093, 64'd5,                 1'b1, 1'b0});
    vecs.push_back('{"addi_x2_x1_m1",  32'hfff0_8113, 64'd4,                 1'b1, 1'b0});
    vecs.push_back('{"read_x2",        32'h0001_0293, 64'd4,                 1'b1, 1'b0});
    vecs.push_back('{"addi_x0_7",      32'h0070_0013, 64'd7,                 1'b1, 1'b0});
    vecs.push_back('{"read_x0",        32'h0000_0193, 64'd0,                 1'b1, 1'b0});
    vecs.push_back('{"imm_min",        32'h8000_0213, 64'hFFFF_FFFF_FFFF_F800, 1'b1, 1'b0});
    vecs.push_back('{"x4_minus1",      32'hfff2_0213, 64'hFFFF_FFFF_FFFF_F7FF, 1'b1, 1'b0});
    vecs.push_back('{"x1_all_ones",    32'hfff0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{"wrap_to_zero",   32'h0010_8093, 64'd0,                 1'b1, 1'b0});
    vecs.push_back('{"read_x1_zero",   32'h0000_8313, 64'd0,                 1'b1, 1'b0});
    vecs.push_back('{"x1_5_again",     32'h0050_0093, 64'd5,                 1'b1, 1'b0});
    vecs.push_back('{"ebreak",         32'h0010_0073, 64'd0,                 1'b0, 1'b1});
    vecs.push_back('{"zero_inst",      32'h0000_0000, 64'd0,                 1'b0, 1'b0});
    vecs.push_back('{"ecall",          32'h0000_0073, 64'd0,                 1'b0, 1'b0});
    vecs.push_back('{"opimm_f3_1",     32'h0050_9093, 64'd0,                 1'b0, 1'b0});
    vecs.push_back('{"op_add",         32'h0050_00b3, 64'd0,                 1'b0, 1'b0});
    vecs.push_back('{"x1_unchanged",   32'h0000_8313, 64'd5,                 1'b1, 1'b0});

    // Reset state: every readable register is zero.
    #1 rst = 1'b1;
    #1 inst = 32'h0000_8313;
    #1 check("reset_x1", 64'd0, 1'b1, 1'b0);
    inst = 32'h0007_8313;
    #1 check("reset_x15", 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) apply(vecs[k].name, vecs[k].inst, vecs[k].out, vecs[k].wen, vecs[k].halt);

    // x1 holds 5 here; an async pulse between edges clears it immediately.
    @(negedge clk);
    inst = 32'h0000_8313;
    #1 check("pre_pulse_x1", 64'd5, 1'b1, 1'b0);
    rst = 1'b1;
    #1 check("pulse_clears_x1", 64'd0, 1'b1, 1'b0);
    rst = 1'b0;
    #1 check("after_pulse_x1", 64'd0, 1'b1, 1'b0);

    // Reset held across a write edge: output still combinational, no write lands.
    @(negedge clk);
    inst = 32'h0090_0093;
    rst  = 1'b1;
    #1 check("rst_addi_out", 64'd9, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    apply("rst_blocked_write", 32'h0000_8313, 64'd0, 1'b1, 1'b0);

    // Writes resume at the first edge after deassertion.
    apply("resume_write", 32'h0090_0093, 64'd9, 1'b1, 1'b0);
    apply("resume_read",  32'h0000_8313, 64'd9, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
